// File: rtl/sram_req_arbiter_if.sv
// sram-like request/response bundle: req/addr_ok request handshake, data_ok/rdata in-order response.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like memory port between instruction-fetch and data masters; an in-order
// tag FIFO remembers who owns each outstanding request so responses route back correctly.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master mem
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       lock_valid;
  logic                       lock_src;
  logic [STV_W-1:0]           starve_cnt;

  logic full;
  logic empty;
  logic starved;
  logic grant_valid;
  logic grant_src;
  logic req_out;
  logic push;
  logic pop;
  logic head;

  assign full    = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (count == '0);
  assign starved = inst.req && (starve_cnt == STV_W'(STARVE_LIMIT));

  // A presented-but-unaccepted request owns the port until it is taken.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_INST;
    if (lock_valid) begin
      grant_valid = 1'b1;
      grant_src   = lock_src;
    end else if (data.req && !starved) begin
      grant_valid = 1'b1;
      grant_src   = SRC_DATA;
    end else if (inst.req) begin
      grant_valid = 1'b1;
      grant_src   = SRC_INST;
    end
  end

  assign req_out = grant_valid && !full;
  assign push    = req_out && mem.addr_ok;
  assign pop     = mem.data_ok && !empty;
  assign head    = tag_mem[rd_ptr];

  always_comb begin
    mem.req   = req_out;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (req_out) begin
      if (grant_src == SRC_DATA) begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.wstrb = data.wstrb;
        mem.addr  = data.addr;
        mem.wdata = data.wdata;
      end else begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.wstrb = inst.wstrb;
        mem.addr  = inst.addr;
        mem.wdata = inst.wdata;
      end
    end
  end

  assign inst.addr_ok = push && (grant_src == SRC_INST);
  assign data.addr_ok = push && (grant_src == SRC_DATA);
  assign inst.data_ok = pop && (head == SRC_INST);
  assign data.data_ok = pop && (head == SRC_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_src;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Lock is left untouched while the port is held off by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_src   <= 1'b0;
    end else if (req_out) begin
      lock_valid <= !mem.addr_ok;
      lock_src   <= grant_src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst.req || (push && grant_src == SRC_INST)) begin
      starve_cnt <= '0;
    end else if (push && grant_src == SRC_DATA && starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: grant priority, lock, full FIFO, starvation guard, response routing, reset.
module tb_sram_req_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  sram_req_arbiter_if inst_bus ();
  sram_req_arbiter_if data_bus ();
  sram_req_arbiter_if mem_bus ();

  sram_req_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_bus),
    .data  (data_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic r, input logic [31:0] a);
    inst_bus.req   = r;
    inst_bus.wr    = 1'b0;
    inst_bus.size  = 2'd2;
    inst_bus.wstrb = 4'hf;
    inst_bus.addr  = a;
    inst_bus.wdata = 32'd0;
  endtask

  task automatic set_data(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
    data_bus.req   = r;
    data_bus.wr    = w;
    data_bus.size  = 2'd2;
    data_bus.wstrb = w ? 4'h3 : 4'h0;
    data_bus.addr  = a;
    data_bus.wdata = wd;
  endtask

  task automatic set_mem(input logic aok, input logic dok, input logic [31:0] rd);
    mem_bus.addr_ok = aok;
    mem_bus.data_ok = dok;
    mem_bus.rdata   = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_inst(1'b0, 32'd0);
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    set_mem(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_bus.req), 32'd0);
    chk("rst_mem_addr", mem_bus.addr, 32'd0);
    chk("rst_inst_aok", 32'(inst_bus.addr_ok), 32'd0);
    chk("rst_data_dok", 32'(data_bus.data_ok), 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);

    // 1: simultaneous requests, data wins first
    set_inst(1'b1, 32'h200);
    set_data(1'b1, 1'b1, 32'h300, 32'hcafe_f00d);
    set_mem(1'b1, 1'b0, 32'd0);
    #1;
    chk("t1_addr_data", mem_bus.addr, 32'h300);
    chk("t1_wr", 32'(mem_bus.wr), 32'd1);
    chk("t1_wdata", mem_bus.wdata, 32'hcafe_f00d);
    chk("t1_wstrb", 32'(mem_bus.wstrb), 32'h3);
    chk("t1_data_aok", 32'(data_bus.addr_ok), 32'd1);
    chk("t1_inst_aok0", 32'(inst_bus.addr_ok), 32'd0);
    tick();
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t1_addr_inst", mem_bus.addr, 32'h200);
    chk("t1_inst_aok", 32'(inst_bus.addr_ok), 32'd1);
    chk("t1_data_aok0", 32'(data_bus.addr_ok), 32'd0);
    tick();
    set_inst(1'b0, 32'd0);
    set_mem(1'b0, 1'b1, 32'h1111_1111);
    #1;
    chk("t1_resp1_data", 32'(data_bus.data_ok), 32'd1);
    chk("t1_resp1_inst", 32'(inst_bus.data_ok), 32'd0);
    chk("t1_resp1_rdata", data_bus.rdata, 32'h1111_1111);
    tick();
    set_mem(1'b0, 1'b1, 32'h2222_2222);
    #1;
    chk("t1_resp2_inst", 32'(inst_bus.data_ok), 32'd1);
    chk("t1_resp2_data", 32'(data_bus.data_ok), 32'd0);
    chk("t1_resp2_rdata", inst_bus.rdata, 32'h2222_2222);
    tick();
    set_mem(1'b0, 1'b0, 32'd0);
    #1;
    chk("t1_count", 32'(dut.count), 32'd0);

    // 2: data request locked while addr_ok stays low
    set_data(1'b1, 1'b0, 32'h100, 32'd0);
    #1;
    chk("t2_c1_addr", mem_bus.addr, 32'h100);
    chk("t2_c1_aok", 32'(data_bus.addr_ok), 32'd0);
    tick();
    set_inst(1'b1, 32'h400);
    #1;
    chk("t2_c2_addr", mem_bus.addr, 32'h100);
    chk("t2_c2_inst_aok", 32'(inst_bus.addr_ok), 32'd0);
    tick();
    #1;
    chk("t2_c3_addr", mem_bus.addr, 32'h100);
    tick();
    set_mem(1'b1, 1'b0, 32'd0);
    #1;
    chk("t2_acc_addr", mem_bus.addr, 32'h100);
    chk("t2_acc_data_aok", 32'(data_bus.addr_ok), 32'd1);
    tick();
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t2_next_addr", mem_bus.addr, 32'h400);
    chk("t2_next_inst_aok", 32'(inst_bus.addr_ok), 32'd1);
    tick();
    set_inst(1'b0, 32'd0);
    set_mem(1'b0, 1'b1, 32'd0);
    #1;
    chk("t2_drain1", 32'(data_bus.data_ok), 32'd1);
    tick();
    #1;
    chk("t2_drain2", 32'(inst_bus.data_ok), 32'd1);
    tick();

    // 2b: inst locked, data rising must not steal the port
    set_mem(1'b0, 1'b0, 32'd0);
    set_inst(1'b1, 32'h500);
    tick();
    set_data(1'b1, 1'b0, 32'h600, 32'd0);
    #1;
    chk("t2b_lock_addr", mem_bus.addr, 32'h500);
    tick();
    set_mem(1'b1, 1'b0, 32'd0);
    #1;
    chk("t2b_inst_aok", 32'(inst_bus.addr_ok), 32'd1);
    chk("t2b_data_aok0", 32'(data_bus.addr_ok), 32'd0);
    tick();
    set_inst(1'b0, 32'd0);
    #1;
    chk("t2b_data_addr", mem_bus.addr, 32'h600);
    chk("t2b_data_aok", 32'(data_bus.addr_ok), 32'd1);
    tick();
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    set_mem(1'b0, 1'b1, 32'd0);
    #1;
    chk("t2b_drain_inst", 32'(inst_bus.data_ok), 32'd1);
    tick();
    #1;
    chk("t2b_drain_data", 32'(data_bus.data_ok), 32'd1);
    tick();

    // 3: fill the tag FIFO
    set_mem(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_inst(1'b1, 32'h10 + 32'(i * 4));
      #1;
      chk("t3_fill_aok", 32'(inst_bus.addr_ok), 32'd1);
      tick();
    end
    set_inst(1'b1, 32'h20);
    #1;
    chk("t3_full_req", 32'(mem_bus.req), 32'd0);
    chk("t3_full_aok", 32'(inst_bus.addr_ok), 32'd0);
    tick();
    set_mem(1'b1, 1'b1, 32'd0);
    #1;
    chk("t3_nobypass_req", 32'(mem_bus.req), 32'd0);
    chk("t3_pop_inst", 32'(inst_bus.data_ok), 32'd1);
    tick();
    set_mem(1'b1, 1'b0, 32'd0);
    #1;
    chk("t3_freed_req", 32'(mem_bus.req), 32'd1);
    chk("t3_freed_aok", 32'(inst_bus.addr_ok), 32'd1);
    tick();
    set_inst(1'b0, 32'd0);
    set_mem(1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    set_mem(1'b0, 1'b0, 32'd0);
    #1;
    chk("t3_drained", 32'(dut.count), 32'd0);

    // 4: starvation guard, both held, one response per cycle
    set_inst(1'b1, 32'h800);
    set_data(1'b1, 1'b0, 32'h700, 32'd0);
    set_mem(1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_grant_addr", mem_bus.addr, ((i % 5) == 4) ? 32'h800 : 32'h700);
      tick();
      if ((i % 5) == 4) chk("t4_starve_zero", 32'(dut.starve_cnt), 32'd0);
    end
    set_inst(1'b0, 32'd0);
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    set_mem(1'b0, 1'b0, 32'd0);
    #1;
    chk("t4_drained", 32'(dut.count), 32'd0);

    // 5: same-cycle push and pop
    set_mem(1'b1, 1'b0, 32'd0);
    set_data(1'b1, 1'b0, 32'ha00, 32'd0);
    tick();
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    set_inst(1'b1, 32'hb00);
    tick();
    set_inst(1'b0, 32'd0);
    set_data(1'b1, 1'b0, 32'hc00, 32'd0);
    set_mem(1'b1, 1'b1, 32'h3333_3333);
    #1;
    chk("t5_pp_count_before", 32'(dut.count), 32'd2);
    chk("t5_pp_aok", 32'(data_bus.addr_ok), 32'd1);
    chk("t5_pp_data_dok", 32'(data_bus.data_ok), 32'd1);
    chk("t5_pp_inst_dok", 32'(inst_bus.data_ok), 32'd0);
    tick();
    set_data(1'b0, 1'b0, 32'd0, 32'd0);
    set_mem(1'b0, 1'b1, 32'd0);
    #1;
    chk("t5_pp_count_after", 32'(dut.count), 32'd2);
    chk("t5_head_inst", 32'(inst_bus.data_ok), 32'd1);
    tick();
    #1;
    chk("t5_head_data", 32'(data_bus.data_ok), 32'd1);
    tick();
    #1;
    chk("t5_stray_inst", 32'(inst_bus.data_ok), 32'd0);
    chk("t5_stray_data", 32'(data_bus.data_ok), 32'd0);
    tick();
    set_mem(1'b0, 1'b0, 32'd0);
    #1;
    chk("t5_stray_count", 32'(dut.count), 32'd0);

    // 6: reset with requests outstanding
    set_mem(1'b1, 1'b0, 32'd0);
    set_inst(1'b1, 32'hd00);
    for (int i = 0; i < 3; i++) tick();
    set_inst(1'b0, 32'd0);
    set_mem(1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_mem(1'b0, 1'b1, 32'h4444_4444);
    #1;
    chk("t6_post_inst_dok", 32'(inst_bus.data_ok), 32'd0);
    chk("t6_post_data_dok", 32'(data_bus.data_ok), 32'd0);
    tick();
    set_mem(1'b1, 1'b0, 32'd0);
    set_inst(1'b1, 32'h900);
    #1;
    chk("t6_new_addr", mem_bus.addr, 32'h900);
    chk("t6_new_aok", 32'(inst_bus.addr_ok), 32'd1);
    tick();
    set_inst(1'b0, 32'd0);
    set_mem(1'b0, 1'b1, 32'h5555_5555);
    #1;
    chk("t6_new_resp", 32'(inst_bus.data_ok), 32'd1);
    chk("t6_new_rdata", inst_bus.rdata, 32'h5555_5555);
    tick();
    set_mem(1'b0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Arbiter that shares one sram-like memory port between the core's instruction-fetch and data (exe/mem) sram-like masters, using the same req/addr_ok/data_ok handshake on all three sides. It grants at most one request per cycle and records the source of every accepted request in an in-order tag FIFO. It routes each returning data_ok/rdata to the owning master. It sits between the pipeline core and the single memory/bus bridge port.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: tag FIFO depth, i.e. the maximum number of accepted but unreturned requests (power of 2, ≥2).
- STARVE_LIMIT, 4: number of consecutive data grants allowed while inst_req is pending.

Ports (`X` = inst | data; each line covers both masters):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- X_req  in  1  master request
- X_wr  in  1  1 = write
- X_size  in  2  0 = byte, 1 = half, 2 = word
- X_wstrb  in  4  byte enables
- X_addr, X_wdata  in  32  address and write data
- X_addr_ok  out  1  request accepted this cycle
- X_data_ok  out  1  response for this master this cycle
- X_rdata  out  32  read data (mem_rdata broadcast)
- mem_req, mem_wr  out  1  granted request and write flag
- mem_size  out  2  granted size
- mem_wstrb  out  4  granted byte enables
- mem_addr, mem_wdata  out  32  granted address and write data
- mem_addr_ok, mem_data_ok  in  1  slave handshake; responses return in order
- mem_rdata  in  32  slave read data

## Operation
Grant selection (combinational, from registered state and current reqs):
- If lock_valid, grant = lock_src.
- Else, if the FIFO is full, there is no grant and mem_req = 0.
- Else, if data_req and not (inst_req and starve_cnt == STARVE_LIMIT), grant = data.
- Else, if inst_req, grant = inst.
- Otherwise there is no grant.

Request path:
- mem_* = fields of the granted master; all zero when there is no grant.
- X_addr_ok = mem_addr_ok & mem_req & (grant == X). The non-granted master sees 0.

Lock:
- A cycle with mem_req=1 and mem_addr_ok=0 sets lock_valid=1 and lock_src=grant.
- Acceptance clears the lock.
- This guarantees a presented request is never swapped before acceptance.

Tag FIFO (MAX_OUTSTANDING entries, 1 bit each: 0 = inst, 1 = data):
- Each accepted request (mem_req & mem_addr_ok) pushes grant.
- Each mem_data_ok pops the head.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo depth.
- Full (count == MAX_OUTSTANDING) blocks new grants. A locked request is also held off, with mem_req dropped, until a slot frees. A pop in the same cycle does not bypass.
- mem_data_ok while the FIFO is empty is ignored: no pop, no underflow, both X_data_ok = 0.

Response path:
- inst_data_ok = mem_data_ok & !empty & (head == 0).
- data_data_ok = mem_data_ok & !empty & (head == 1).
- X_rdata = mem_rdata. Write responses are routed identically.

starve_cnt (0..STARVE_LIMIT):
- Increments on each accepted data request while inst_req = 1, saturating.
- Resets to 0 on any accepted inst request, or whenever inst_req = 0.

## Timing
- Zero-cycle pass-through in both directions: request to mem_req, mem_addr_ok to X_addr_ok, mem_data_ok to X_data_ok. There are no combinational paths from X_addr_ok or X_data_ok back into grant.
- Maximum throughput is one acceptance per cycle. Up to MAX_OUTSTANDING requests can be in flight.
- Reset values:
  - All registered state is 0: count, pointers, lock_valid, lock_src, starve_cnt.
  - All outputs are 0 while no request is asserted.
- Reset mid-operation: outstanding tags are discarded. Post-reset stray mem_data_ok is ignored by the empty-FIFO rule.
- An X_req deasserted while locked is a master protocol violation. The lock still holds until acceptance or reset.

## Test plan
1. Simultaneous requests: inst_req = data_req = 1, mem_addr_ok = 1, FIFO empty.
   - The data request is accepted first: data_addr_ok = 1, inst_addr_ok = 0, tag 1 pushed.
   - The inst request is accepted the next cycle.
   - Two mem_data_ok pulses then yield data_data_ok and then inst_data_ok, with rdata 0x11111111 and 0x22222222 respectively.
2. Lock hold: data_req at address 0x100 is presented with mem_addr_ok = 0 for 3 cycles, and inst_req rises in cycle 2.
   - mem_addr stays 0x100 throughout.
   - On mem_addr_ok = 1 the data request is accepted.
   - The inst request is granted the following cycle.
3. Full FIFO: 4 inst requests are accepted with no data_ok, then a 5th is presented.
   - mem_req = 0 while the FIFO is full.
   - One mem_data_ok pulse makes mem_req = 1 on the next cycle.
4. Starvation guard: data_req and inst_req are held continuously with mem_addr_ok = 1.
   - The grant sequence is data ×4, then inst, repeating.
   - starve_cnt returns to 0 after each inst grant.
5. Same-cycle push/pop: with 2 requests outstanding, an accept and a mem_data_ok occur together.
   - Count stays 2 and the head tag routes correctly.
   - A stray mem_data_ok with the FIFO empty produces no X_data_ok.
6. Reset mid-operation: reset is asserted with 3 requests outstanding.
   - After reset, a mem_data_ok pulse gives inst_data_ok = data_data_ok = 0.
   - A new inst request is then accepted normally.
